// File: rtl/tm1638_key_reader.sv
// tm1638_key_reader: issues the TM1638 key-scan read command (0x42), clocks in four scan bytes,
// and presents the raw 32-bit scan together with the decoded S1..S8 button vector.
module tm1638_key_reader #(
    parameter int CLK_DIV  = 25,
    parameter int WAIT_CYC = 100
) (
    input  logic        clki,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [7:0]  keys,
    output logic [31:0] raw,
    output logic        stb,
    output logic        tm_clk,
    output logic        dio_out,
    output logic        dio_oe,
    input  logic        dio_in
);
    typedef enum logic [2:0] {IDLE, STB_SETUP, CMD, WAIT, READ, STB_HOLD} state_t;

    localparam logic [7:0] CMD_BYTE = 8'h42;
    localparam int CNT_MAX = CLK_DIV > WAIT_CYC ? CLK_DIV : WAIT_CYC;
    localparam int CW = $clog2(CNT_MAX);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          half, half_n;
    logic [4:0]    bit_cnt, bit_n;
    logic [31:0]   sr, sr_n;
    logic          last, finish;
    logic          stb_d, clk_d, oe_d, out_d, busy_d;

    assign last = cnt == CW'((state == WAIT ? WAIT_CYC : CLK_DIV) - 1);

    always_ff @(posedge clki) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            half    <= 1'b0;
            bit_cnt <= '0;
            sr      <= '0;
            stb     <= 1'b1;
            tm_clk  <= 1'b1;
            dio_oe  <= 1'b0;
            dio_out <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            keys    <= '0;
            raw     <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            half    <= half_n;
            bit_cnt <= bit_n;
            sr      <= sr_n;
            stb     <= stb_d;
            tm_clk  <= clk_d;
            dio_oe  <= oe_d;
            dio_out <= out_d;
            busy    <= busy_d;
            done    <= finish;
            if (finish) begin
                raw  <= sr;
                keys <= {sr[28], sr[20], sr[12], sr[4], sr[24], sr[16], sr[8], sr[0]};
            end
        end
    end

    // half=0 is the tm_clk-low phase of a bit; the read sample lands on the last high cycle
    always_comb begin
        state_n = state;
        cnt_n   = last ? '0 : cnt + 1'b1;
        half_n  = half;
        bit_n   = bit_cnt;
        sr_n    = sr;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (start) state_n = STB_SETUP;
            end
            STB_SETUP: if (last) state_n = CMD;
            CMD, READ: if (last) begin
                half_n = !half;
                if (half) begin
                    bit_n = bit_cnt + 1'b1;
                    if (state == READ) sr_n[bit_cnt] = dio_in;
                    if (state == CMD && bit_cnt == 5'd7) begin
                        state_n = WAIT;
                        bit_n   = '0;
                    end
                    if (state == READ && bit_cnt == 5'd31) state_n = STB_HOLD;
                end
            end
            WAIT:     if (last) state_n = READ;
            STB_HOLD: if (last) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_comb begin
        stb_d  = state_n == IDLE;
        clk_d  = !((state_n == CMD || state_n == READ) && !half_n);
        oe_d   = state_n == STB_SETUP || state_n == CMD;
        out_d  = state_n == CMD ? CMD_BYTE[bit_n[2:0]] : 1'b1;
        busy_d = state_n != IDLE;
        finish = state == STB_HOLD && last;
    end
endmodule

// File: doc/tm1638_key_reader.md
# tm1638_key_reader

Read-side master for the TM1638 LED/key driver board. On a start pulse it issues the "read key-scan data" command (0x42) on the shared STB/CLK/DIO bus, releases DIO, clocks in the four key-scan bytes and presents both the raw 32-bit scan and the decoded 8-button vector. It runs on the board system clock and complements the display-write path in the lighting design.

## Interface

Parameters:
- CLK_DIV, 25: system clocks per TM1638 CLK half-period; must be ≥2. At 50 MHz this gives 1 MHz.
- WAIT_CYC, 100: system clocks between the last command bit and the first read clock (Twait); must be ≥1.

Ports:
- clki  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request one read transaction; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; keys and raw are valid from this cycle onward.
- keys  output  8  decoded buttons S1..S8 (bit i = S(i+1)), held until the next done.
- raw  output  32  {byte3, byte2, byte1, byte0} as received.
- stb  output  1  TM1638 STB, active low.
- tm_clk  output  1  TM1638 CLK; idles high.
- dio_out  output  1  DIO drive value.
- dio_oe  output  1  DIO drive enable; the top-level tri-state buffer uses it.
- dio_in  input  1  DIO pad value.

## Operation

- States: IDLE → STB_SETUP → CMD → WAIT → READ → STB_HOLD → IDLE.
- Reset values (registered, applied on the rst_n=0 edge, including mid-transaction):
  - stb=1, tm_clk=1, dio_oe=0, dio_out=1
  - busy=0, done=0, keys=0, raw=0
  - state IDLE, all counters 0
- IDLE:
  - start=1 → STB_SETUP; stb=0 and busy=1 take effect on that edge.
- STB_SETUP: holds for CLK_DIV cycles with tm_clk=1 and dio_oe=1.
- CMD:
  - Shifts 8 bits of 0x42, LSB first (0,1,0,0,0,0,1,0).
  - Each bit is CLK_DIV cycles with tm_clk=0 followed by CLK_DIV cycles with tm_clk=1.
  - dio_out changes only on the edge that drives tm_clk low.
- WAIT:
  - Entered with tm_clk=1, dio_oe=0, dio_out=1.
  - Holds for WAIT_CYC cycles.
- READ:
  - 32 bits, each CLK_DIV cycles low followed by CLK_DIV cycles high.
  - dio_in is sampled on the last cycle of each high phase.
  - Bit n goes to shift-register position n: byte 0 first, LSB first.
- STB_HOLD:
  - Holds for CLK_DIV cycles with tm_clk=1 and stb=0.
  - On exit, in the same edge: stb=1, done=1, busy=0, raw updated, keys updated.
- Key decode, for b=0..3:
  - keys[b] = raw[8b+0]
  - keys[b+4] = raw[8b+4]
  - All other raw bits are ignored for keys.
- Boundary conditions:
  - start while busy: ignored, not queued.
  - start high in the cycle after done: accepted normally.
  - start held high continuously: back-to-back transactions with one IDLE cycle between them.
  - Reset mid-transaction: the bus returns to idle immediately, and no done is produced.
  - dio_in is never sampled while dio_oe=1.

## Timing

- Transaction length N = 82·CLK_DIV + WAIT_CYC cycles, counted from the start-accepting edge to the edge that raises done.
  - Defaults: N = 2150.
- stb stays low for exactly N cycles.
- Number of tm_clk falling edges per transaction: exactly 40 (8 command + 32 read).
- dio_oe is high only during STB_SETUP and CMD; it falls on the same edge as the final command high phase ends.
- done is high for exactly one cycle; busy is low during that same cycle.
- keys and raw change only on a done edge or on reset.
- Minimum start-to-start period: N+1 cycles.

## Test plan

- Reset: assert rst_n=0 for 2 cycles, then release.
  - Expect stb=1, tm_clk=1, dio_oe=0, busy=0, done=0, keys=0x00, raw=0.
- Command waveform (CLK_DIV=2, WAIT_CYC=5):
  - Capture dio_out at each tm_clk rise during CMD; expect 0,1,0,0,0,0,1,0.
  - Expect dio_oe=0 before the first read clock.
  - Expect the WAIT gap to be 5 cycles.
- Key read: a bus model drives bytes 0x01, 0x10, 0x00, 0x11 on the falling edges.
  - Expect raw=0x11001001 and keys=0xA9.
  - Expect done to rise exactly N=169 cycles after start.
- Busy protection: pulse start at cycles 10, 50 and 100 of a transaction.
  - Expect a single transaction and a single done.
  - Expect exactly 40 tm_clk falling edges.
- Reset mid-read: drop rst_n during READ bit 17.
  - Next edge: stb=1, tm_clk=1, busy=0, and keys/raw cleared to 0.
  - Expect no done pulse.
- Back-to-back: hold start=1.
  - Expect done pulses spaced N+1 cycles apart.
  - Expect the second transaction to report a new bus pattern (0xFF ×4 → keys=0xFF).
